// File: rtl/branch_pc_unit.sv
// PC register and branch resolution stage: evaluates the branch condition from
// ALU flags and the stored carry, selects the next PC, and runs the halt/resume FSM.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        resume,
    input  logic [3:0]  branch_op,
    input  logic [31:0] offset,
    input  logic [31:0] alu_result,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        flag_we,
    output logic [31:0] pc,
    output logic        carry_flag,
    output logic        taken,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        flush,
    output logic        halted
);

    localparam logic [3:0] OP_B    = 4'd1;
    localparam logic [3:0] OP_BR   = 4'd2;
    localparam logic [3:0] OP_BLTZ = 4'd3;
    localparam logic [3:0] OP_BZ   = 4'd4;
    localparam logic [3:0] OP_BNZ  = 4'd5;
    localparam logic [3:0] OP_BL   = 4'd6;
    localparam logic [3:0] OP_BCY  = 4'd7;
    localparam logic [3:0] OP_BNCY = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state;
    logic        cond;
    logic        active;
    logic [31:0] seq_pc;
    logic [31:0] target;

    assign active    = (state == RUN) && !stall;
    assign seq_pc    = pc + 32'd4;
    assign link_data = seq_pc;
    assign halted    = (state == HALTED);

    // Carry-conditioned branches look at the registered flag, not this cycle's ALU carry
    always_comb begin
        cond = 1'b0;
        case (branch_op)
            OP_B, OP_BR, OP_BL: cond = 1'b1;
            OP_BLTZ:            cond = alu_negative;
            OP_BZ:              cond = alu_zero;
            OP_BNZ:             cond = !alu_zero;
            OP_BCY:             cond = carry_flag;
            OP_BNCY:            cond = !carry_flag;
            default:            cond = 1'b0;
        endcase
    end

    assign taken   = cond && active;
    assign link_we = (branch_op == OP_BL) && active;
    assign target  = (branch_op == OP_BR) ? {alu_result[31:2], 2'b00} : pc + offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            carry_flag <= 1'b0;
            flush      <= 1'b0;
            state      <= RUN;
        end else begin
            flush <= 1'b0;
            case (state)
                RUN: begin
                    if (!stall) begin
                        flush <= taken;
                        if (flag_we)
                            carry_flag <= alu_carry;
                        // A HALT keeps its own address in pc; resume advances past it
                        if (branch_op == OP_HALT)
                            state <= HALTED;
                        else
                            pc <= taken ? target : seq_pc;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state <= RUN;
                        pc    <= seq_pc;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed-vector bench for branch_pc_unit: a table of one-cycle vectors walked in
// order, plus a hand sequence for asynchronous reset while halted.
module tb_branch_pc_unit;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] offset;
        logic [31:0] alu_res;
        logic        neg;
        logic        zero;
        logic        cy;
        logic        fwe;
        logic        stall;
        logic        resume;
        logic        exp_taken;
        logic        exp_link_we;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_carry;
        logic        exp_halted;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        resume;
    logic [3:0]  branch_op;
    logic [31:0] offset;
    logic [31:0] alu_result;
    logic        alu_negative;
    logic        alu_zero;
    logic        alu_carry;
    logic        flag_we;
    logic [31:0] pc;
    logic        carry_flag;
    logic        taken;
    logic        link_we;
    logic [31:0] link_data;
    logic        flush;
    logic        halted;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    logic [31:0] cur_pc;

    branch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .stall(stall), .resume(resume),
        .branch_op(branch_op), .offset(offset), .alu_result(alu_result),
        .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .flag_we(flag_we), .pc(pc), .carry_flag(carry_flag), .taken(taken),
        .link_we(link_we), .link_data(link_data), .flush(flush), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] off,
                                input logic [31:0] ar, input logic n, input logic z,
                                input logic c, input logic fw, input logic st,
                                input logic rs, input logic et, input logic el,
                                input logic [31:0] ep, input logic ef, input logic ec,
                                input logic eh);
        vec_t v;
        v.op = op; v.offset = off; v.alu_res = ar; v.neg = n; v.zero = z; v.cy = c;
        v.fwe = fw; v.stall = st; v.resume = rs; v.exp_taken = et; v.exp_link_we = el;
        v.exp_pc = ep; v.exp_flush = ef; v.exp_carry = ec; v.exp_halted = eh;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        branch_op    = v.op;
        offset       = v.offset;
        alu_result   = v.alu_res;
        alu_negative = v.neg;
        alu_zero     = v.zero;
        alu_carry    = v.cy;
        flag_we      = v.fwe;
        stall        = v.stall;
        resume       = v.resume;
    endtask

    initial begin
        // op, offset, alu_result, neg, zero, cy, fwe, stall, resume,
        // exp taken, link_we, pc after edge, flush, carry, halted
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h108, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10C, 0, 0, 0));
        vecs.push_back(mk(2, 0, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0, 32'h200, 1, 0, 0));
        vecs.push_back(mk(4, 32'hFFFF_FFF8, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h1F8, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1FC, 0, 0, 0));
        vecs.push_back(mk(2, 0, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0, 32'h200, 1, 0, 0));
        vecs.push_back(mk(4, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h204, 0, 0, 0));
        vecs.push_back(mk(5, 32'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h214, 1, 0, 0));
        vecs.push_back(mk(3, 32'hFFFF_FFEC, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h200, 1, 0, 0));
        vecs.push_back(mk(3, 32'hFFFF_FFEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h204, 0, 0, 0));
        vecs.push_back(mk(2, 0, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40, 1, 0, 0));
        vecs.push_back(mk(7, 32'h20, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h44, 0, 1, 0));
        vecs.push_back(mk(7, 32'h20, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h64, 1, 1, 0));
        vecs.push_back(mk(8, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h68, 0, 1, 0));
        vecs.push_back(mk(8, 32'h10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h6C, 0, 0, 0));
        vecs.push_back(mk(8, 32'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h7C, 1, 0, 0));
        vecs.push_back(mk(2, 0, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0, 32'h300, 1, 0, 0));
        vecs.push_back(mk(6, 32'h40, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h340, 1, 0, 0));
        vecs.push_back(mk(2, 0, 32'h1237, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 1, 0, 0));
        vecs.push_back(mk(2, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h10, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(6, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(12, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0));
        vecs.push_back(mk(2, 0, 32'h80, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80, 1, 0, 0));
        vecs.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 0, 1));
        vecs.push_back(mk(1, 32'h40, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h80, 0, 0, 1));
        vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 0, 1));
        vecs.push_back(mk(6, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h80, 0, 0, 1));
        vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 0, 1));
        vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 0, 1));
        vecs.push_back(mk(1, 32'h40, 0, 0, 0, 1, 1, 1, 1, 0, 0, 32'h84, 0, 0, 0));

        rst = 1'b1;
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check_output("reset pc", pc, 32'h100);
        check_output("reset flush", {31'b0, flush}, 32'h0);
        check_output("reset carry", {31'b0, carry_flag}, 32'h0);
        check_output("reset halted", {31'b0, halted}, 32'h0);
        rst = 1'b0;
        cur_pc = 32'h100;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            #2;
            check_output($sformatf("v%0d taken", i), {31'b0, taken}, {31'b0, vecs[i].exp_taken});
            check_output($sformatf("v%0d link_we", i), {31'b0, link_we}, {31'b0, vecs[i].exp_link_we});
            check_output($sformatf("v%0d link_data", i), link_data, cur_pc + 32'd4);
            @(posedge clk);
            #1;
            check_output($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
            check_output($sformatf("v%0d flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
            check_output($sformatf("v%0d carry", i), {31'b0, carry_flag}, {31'b0, vecs[i].exp_carry});
            check_output($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].exp_halted});
            cur_pc = vecs[i].exp_pc;
        end

        // Set carry, halt, then reset mid-cycle while halted
        apply_stimulus(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_output("seq carry set", {31'b0, carry_flag}, 32'h1);
        check_output("seq pc 88", pc, 32'h88);
        apply_stimulus(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_output("seq halted", {31'b0, halted}, 32'h1);
        check_output("seq halt pc", pc, 32'h88);
        apply_stimulus(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        check_output("async rst pc", pc, 32'h100);
        check_output("async rst halted", {31'b0, halted}, 32'h0);
        check_output("async rst carry", {31'b0, carry_flag}, 32'h0);
        @(posedge clk);
        #1;
        check_output("rst held pc", pc, 32'h100);
        rst = 1'b0;
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_output("post rst pc", pc, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
